// File: rtl/axis_fifo_master.sv
// Beat FIFO between the AXI-Stream ingress slave stage and the packet parser:
// circular array plus a registered first-word-fall-through output stage.
module axis_fifo_master #(
    parameter int data_width = 64,
    parameter int data_user  = 128,
    parameter int depth      = 16
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [data_width-1:0]           fifo_wdata,
    input  logic [data_width/8-1:0]         fifo_wkeep,
    input  logic                            fifo_wlast,
    input  logic [data_user-1:0]            fifo_wuser,
    input  logic                            fifo_wen,
    output logic                            fifo_full,
    output logic [data_width-1:0]           m_axis_tdata,
    output logic [data_width/8-1:0]         m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic [data_user-1:0]            m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [$clog2(depth+1)-1:0]      level,
    output logic [$clog2(depth+1)-1:0]      pkt_count,
    output logic                            overflow
);

    localparam int keep_width  = data_width / 8;
    localparam int ptr_width   = $clog2(depth);
    localparam int level_width = $clog2(depth + 1);
    localparam int array_depth = depth - 1;

    localparam logic [level_width-1:0] level_max  = level_width'(depth);
    localparam logic [level_width-1:0] full_mark  = level_width'(depth - 1);
    localparam logic [ptr_width-1:0]   ptr_last   = ptr_width'(array_depth - 1);

    typedef struct packed {
        logic [data_width-1:0] data;
        logic [keep_width-1:0] keep;
        logic                  last;
        logic [data_user-1:0]  user;
    } beat_t;

    beat_t                   mem [array_depth];
    beat_t                   wr_beat;
    beat_t                   out_beat;
    logic [ptr_width-1:0]    wr_ptr;
    logic [ptr_width-1:0]    rd_ptr;
    logic [level_width-1:0]  arr_count;
    logic [level_width-1:0]  level_next;
    logic [level_width-1:0]  pkt_next;

    logic handshake;
    logic arr_empty;
    logic wr_accept;
    logic bypass;
    logic arr_push;
    logic arr_pop;
    logic pkt_inc;
    logic pkt_dec;

    // Pointers wrap modulo depth-1, so the step is not a plain power-of-two roll-over.
    function automatic logic [ptr_width-1:0] ptr_inc(input logic [ptr_width-1:0] p);
        return (p == ptr_last) ? '0 : p + ptr_width'(1);
    endfunction

    assign wr_beat = '{data: fifo_wdata, keep: fifo_wkeep, last: fifo_wlast, user: fifo_wuser};

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        handshake = m_axis_tvalid && m_axis_tready;
        arr_empty = (arr_count == '0);
        // A handshake on the same edge frees the slot a write at full level needs.
        wr_accept = fifo_wen && ((level < level_max) || handshake);
        bypass    = wr_accept && (!m_axis_tvalid || handshake) && arr_empty;
        arr_push  = wr_accept && !bypass;
        arr_pop   = handshake && !arr_empty;
        pkt_inc   = wr_accept && fifo_wlast;
        pkt_dec   = handshake && m_axis_tlast;

        level_next = level;
        case ({wr_accept, handshake})
            2'b10:   level_next = level + level_width'(1);
            2'b01:   level_next = level - level_width'(1);
            default: level_next = level;
        endcase

        pkt_next = pkt_count;
        case ({pkt_inc, pkt_dec})
            2'b10:   pkt_next = pkt_count + level_width'(1);
            2'b01:   pkt_next = pkt_count - level_width'(1);
            default: pkt_next = pkt_count;
        endcase
    end

    // NOTE: the storage array has no reset; pointers and counts alone define which entries are live.
    always_ff @(posedge aclk) begin
        if (arr_push) begin
            mem[wr_ptr] <= wr_beat;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            arr_count     <= '0;
            level         <= '0;
            pkt_count     <= '0;
            fifo_full     <= 1'b0;
            overflow      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            out_beat      <= '0;
        end else begin
            if (arr_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (arr_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            case ({arr_push, arr_pop})
                2'b10:   arr_count <= arr_count + level_width'(1);
                2'b01:   arr_count <= arr_count - level_width'(1);
                default: arr_count <= arr_count;
            endcase

            if (arr_pop) begin
                out_beat      <= mem[rd_ptr];
                m_axis_tvalid <= 1'b1;
            end else if (bypass) begin
                out_beat      <= wr_beat;
                m_axis_tvalid <= 1'b1;
            end else if (handshake) begin
                m_axis_tvalid <= 1'b0;
            end

            level     <= level_next;
            pkt_count <= pkt_next;
            // Threshold one below capacity leaves room for the write already in flight.
            fifo_full <= (level_next >= full_mark);

            if (fifo_wen && !wr_accept) begin
                overflow <= 1'b1;
            end
        end
    end

    assign m_axis_tdata = out_beat.data;
    assign m_axis_tkeep = out_beat.keep;
    assign m_axis_tlast = out_beat.last;
    assign m_axis_tuser = out_beat.user;

endmodule

// File: tb/tb_axis_fifo_master.sv
// Randomized bench for axis_fifo_master against a queue-based reference model.
module tb_axis_fifo_master;

    localparam int data_width = 64;
    localparam int data_user  = 128;
    localparam int depth      = 16;
    localparam int keep_width = data_width / 8;
    localparam int level_width = $clog2(depth + 1);

    typedef struct {
        logic [data_width-1:0] data;
        logic [keep_width-1:0] keep;
        logic                  last;
        logic [data_user-1:0]  user;
    } beat_t;

    logic                   aclk = 1'b0;
    logic                   aresetn = 1'b0;
    logic [data_width-1:0]  fifo_wdata = '0;
    logic [keep_width-1:0]  fifo_wkeep = '0;
    logic                   fifo_wlast = 1'b0;
    logic [data_user-1:0]   fifo_wuser = '0;
    logic                   fifo_wen = 1'b0;
    logic                   fifo_full;
    logic [data_width-1:0]  m_axis_tdata;
    logic [keep_width-1:0]  m_axis_tkeep;
    logic                   m_axis_tlast;
    logic [data_user-1:0]   m_axis_tuser;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready = 1'b0;
    logic [level_width-1:0] level;
    logic [level_width-1:0] pkt_count;
    logic                   overflow;

    int    vectors = 0;
    int    miscompares = 0;
    beat_t model_q[$];
    bit    model_ovf = 1'b0;

    axis_fifo_master #(
        .data_width(data_width),
        .data_user (data_user),
        .depth     (depth)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .fifo_wdata   (fifo_wdata),
        .fifo_wkeep   (fifo_wkeep),
        .fifo_wlast   (fifo_wlast),
        .fifo_wuser   (fifo_wuser),
        .fifo_wen     (fifo_wen),
        .fifo_full    (fifo_full),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .level        (level),
        .pkt_count    (pkt_count),
        .overflow     (overflow)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t rand_beat(input bit last);
        beat_t b;
        b.data = {$urandom, $urandom};
        b.keep = keep_width'($urandom);
        b.last = last;
        b.user = {$urandom, $urandom, $urandom, $urandom};
        return b;
    endfunction

    // Expected outputs follow directly from the queue: the head is always presented.
    task automatic compare_outputs(input string tag);
        int pkts = 0;
        foreach (model_q[i]) if (model_q[i].last) pkts++;
        check({tag, ".tvalid"}, 128'(m_axis_tvalid), 128'(model_q.size() > 0));
        check({tag, ".level"}, 128'(level), 128'(model_q.size()));
        check({tag, ".pkt_count"}, 128'(pkt_count), 128'(pkts));
        check({tag, ".fifo_full"}, 128'(fifo_full), 128'(model_q.size() >= depth - 1));
        check({tag, ".overflow"}, 128'(overflow), 128'(model_ovf));
        if (model_q.size() > 0) begin
            check({tag, ".tdata"}, 128'(m_axis_tdata), 128'(model_q[0].data));
            check({tag, ".tkeep"}, 128'(m_axis_tkeep), 128'(model_q[0].keep));
            check({tag, ".tlast"}, 128'(m_axis_tlast), 128'(model_q[0].last));
            check({tag, ".tuser"}, m_axis_tuser, model_q[0].user);
        end
    endtask

    // One clock: drive inputs, advance the model by one edge, then compare.
    task automatic cycle(input string tag, input bit wen, input bit ready, input beat_t b);
        bit    hs;
        bit    acc;
        beat_t gone;
        fifo_wen      = wen;
        m_axis_tready = ready;
        fifo_wdata    = b.data;
        fifo_wkeep    = b.keep;
        fifo_wlast    = b.last;
        fifo_wuser    = b.user;
        hs  = (model_q.size() > 0) && ready;
        acc = wen && ((model_q.size() < depth) || hs);
        @(posedge aclk);
        #1;
        if (hs) gone = model_q.pop_front();
        if (acc) model_q.push_back(b);
        if (wen && !acc) model_ovf = 1'b1;
        compare_outputs(tag);
    endtask

    initial begin
        beat_t b;
        int    beat_no;

        // Reset values, both during reset and right after release.
        #12;
        check("rst.tvalid", 128'(m_axis_tvalid), 128'(0));
        check("rst.tdata", 128'(m_axis_tdata), 128'(0));
        check("rst.tuser", m_axis_tuser, 128'(0));
        aresetn = 1'b1;
        compare_outputs("rst_rel");

        // Single known beat, consumed on the following edge.
        b.data = 64'h1122_3344_5566_7788;
        b.keep = 8'hFF;
        b.last = 1'b1;
        b.user = 128'h5;
        cycle("single_wr", 1'b1, 1'b1, b);
        check("single.tdata", 128'(m_axis_tdata), 128'h1122_3344_5566_7788);
        check("single.level", 128'(level), 128'(1));
        cycle("single_hs", 1'b0, 1'b1, b);
        check("single.empty", 128'(level), 128'(0));

        // Fill with tready low: 16 accepted, the 17th dropped.
        for (int i = 0; i < depth + 1; i++)
            cycle("fill", 1'b1, 1'b0, rand_beat(i % 4 == 3 || i == depth - 1));
        check("fill.level", 128'(level), 128'(depth));
        check("fill.overflow", 128'(overflow), 128'(1));

        // Drain in order without bubbles.
        for (int i = 0; i < depth + 1; i++)
            cycle("drain", 1'b0, 1'b1, rand_beat(1'b0));

        // Streaming at full throughput.
        for (int i = 0; i < 100; i++)
            cycle("stream", 1'b1, 1'b1, rand_beat(i % 5 == 4));
        cycle("stream_end", 1'b0, 1'b1, rand_beat(1'b0));

        // Random backpressure over 3-beat packets.
        beat_no = 0;
        for (int i = 0; i < 300; i++) begin
            bit wen;
            wen = ($urandom_range(0, 99) < 70);
            cycle("rand", wen, $urandom_range(0, 1) == 1, rand_beat(beat_no % 3 == 2));
            if (wen) beat_no++;
        end
        for (int i = 0; i < depth + 2; i++)
            cycle("rand_drain", 1'b0, 1'b1, rand_beat(1'b0));

        // Asynchronous reset with seven beats held.
        for (int i = 0; i < 7; i++)
            cycle("prerst", 1'b1, 1'b0, rand_beat(i == 3));
        check("prerst.level", 128'(level), 128'(7));
        #2;
        aresetn  = 1'b0;
        fifo_wen = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        compare_outputs("async_rst");
        check("async_rst.tdata", 128'(m_axis_tdata), 128'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        cycle("post_rst_idle", 1'b0, 1'b0, rand_beat(1'b0));
        cycle("post_rst_wr", 1'b1, 1'b0, rand_beat(1'b1));
        check("post_rst.tvalid", 128'(m_axis_tvalid), 128'(1));
        cycle("post_rst_hs", 1'b0, 1'b1, rand_beat(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
